// File: rtl/cond_exec_unit.sv
// cond_exec_unit: per-context NZCV status, ARM condition evaluation,
// IT-style predicated blocks, one-deep registered valid/ready output.
module cond_exec_unit #(
  parameter int CTX_W    = 1,
  parameter int CNT_W    = 3,
  parameter int BLK_MAX  = 4,
  parameter int BYPASS   = 1,
  parameter int NV_NEVER = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTX_W-1:0]         in_ctx,
  input  logic [3:0]               in_cond,
  input  logic                     in_blk_start,
  input  logic [CNT_W-1:0]         in_blk_len,
  input  logic                     flag_we,
  input  logic [CTX_W-1:0]         flag_ctx,
  input  logic [3:0]               flag_val,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTX_W-1:0]         out_ctx,
  output logic                     out_exec,
  output logic                     out_in_blk,
  output logic [4*(2**CTX_W)-1:0]  status
);

  localparam int NUM_CTX = 2**CTX_W;
  localparam logic [CNT_W-1:0] BLK_LIM = CNT_W'(BLK_MAX);

  logic [3:0]       stat     [NUM_CTX];
  logic [CNT_W-1:0] blk_cnt  [NUM_CTX];
  logic [3:0]       blk_cond [NUM_CTX];

  logic             acc;
  logic [3:0]       fl;
  logic             z, c, n, v;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] start_cnt;
  logic [3:0]       eff;
  logic             in_blk;
  logic             pass;

  assign in_ready = ~out_valid | out_ready;
  assign acc      = in_valid & in_ready;
  assign cur_cnt  = blk_cnt[in_ctx];

  assign fl = (BYPASS != 0 && flag_we && flag_ctx == in_ctx)
            ? flag_val : stat[in_ctx];
  assign z = fl[3];
  assign c = fl[2];
  assign n = fl[1];
  assign v = fl[0];

  assign start_cnt = (in_blk_len > BLK_LIM) ? BLK_LIM : in_blk_len;

  // Pick the governing condition and evaluate it against the flags.
  always_comb begin
    in_blk = 1'b0;
    eff    = in_cond;
    pass   = 1'b0;
    if (in_blk_start) begin
      eff = 4'hE;
    end else if (cur_cnt != '0) begin
      eff    = blk_cond[in_ctx];
      in_blk = 1'b1;
    end
    case (eff)
      4'h0: pass = z;
      4'h1: pass = ~z;
      4'h2: pass = c;
      4'h3: pass = ~c;
      4'h4: pass = n;
      4'h5: pass = ~n;
      4'h6: pass = v;
      4'h7: pass = ~v;
      4'h8: pass = c & ~z;
      4'h9: pass = ~c | z;
      4'hA: pass = (n == v);
      4'hB: pass = (n != v);
      4'hC: pass = ~z & (n == v);
      4'hD: pass = z | (n != v);
      4'hE: pass = 1'b1;
      4'hF: pass = (NV_NEVER == 0);
      default: pass = 1'b0;
    endcase
  end

  // Status registers follow writeback independent of stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CTX; k++) stat[k] <= '0;
    end else if (flag_we) begin
      stat[flag_ctx] <= flag_val;
    end
  end

  // Block state of the accepted context: open/replace or count down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CTX; k++) begin
        blk_cnt[k]  <= '0;
        blk_cond[k] <= '0;
      end
    end else if (acc) begin
      if (in_blk_start) begin
        blk_cond[in_ctx] <= in_cond;
        blk_cnt[in_ctx]  <= start_cnt;
      end else if (cur_cnt != '0) begin
        blk_cnt[in_ctx] <= cur_cnt - 1'b1;
      end
    end
  end

  // Output stage: load on accept, drain when downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_ctx    <= '0;
      out_exec   <= 1'b0;
      out_in_blk <= 1'b0;
    end else if (acc) begin
      out_valid  <= 1'b1;
      out_ctx    <= in_ctx;
      out_exec   <= pass;
      out_in_blk <= in_blk;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_CTX; k++) begin : g_stat
    assign status[4*k +: 4] = stat[k];
  end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Bench for cond_exec_unit: two configurations driven in lockstep
// and compared against a flag/block reference model.
module tb_cond_exec_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ctx;
  logic [3:0] in_cond;
  logic       in_blk_start;
  logic [2:0] in_blk_len;
  logic       flag_we;
  logic       flag_ctx;
  logic [3:0] flag_val;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_ctx, a_out_exec, a_out_in_blk;
  logic [7:0] a_status;
  logic       b_in_ready, b_out_valid, b_out_ctx, b_out_exec, b_out_in_blk;
  logic [7:0] b_status;

  int total = 0;
  int bad   = 0;

  cond_exec_unit #(
    .CTX_W(1), .CNT_W(3), .BLK_MAX(4), .BYPASS(1), .NV_NEVER(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ctx(in_ctx), .in_cond(in_cond),
    .in_blk_start(in_blk_start), .in_blk_len(in_blk_len),
    .flag_we(flag_we), .flag_ctx(flag_ctx), .flag_val(flag_val),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_ctx(a_out_ctx), .out_exec(a_out_exec),
    .out_in_blk(a_out_in_blk), .status(a_status)
  );

  cond_exec_unit #(
    .CTX_W(1), .CNT_W(3), .BLK_MAX(4), .BYPASS(0), .NV_NEVER(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ctx(in_ctx), .in_cond(in_cond),
    .in_blk_start(in_blk_start), .in_blk_len(in_blk_len),
    .flag_we(flag_we), .flag_ctx(flag_ctx), .flag_val(flag_val),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ctx(b_out_ctx), .out_exec(b_out_exec),
    .out_in_blk(b_out_in_blk), .status(b_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int m_stat [2];
  int m_cnt  [2];
  int m_cond [2];
  bit e_valid;
  int e_ctx;
  int e_exec [2];
  int e_blk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ARM rule: cond[3:1] picks a base test, cond[0] inverts (except 1111).
  function automatic int truth(input int cnd, input int f, input bit nvn);
    bit z, c, n, v, base;
    z = f[3]; c = f[2]; n = f[1]; v = f[0];
    if (cnd == 15) return nvn ? 0 : 1;
    case (cnd / 2)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = c && !z;
      5: base = (n == v);
      6: base = (n == v) && !z;
      default: base = 1;
    endcase
    if (cnd % 2 == 1 && cnd != 14) base = !base;
    return base ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_stat[k] = 0; m_cnt[k] = 0; m_cond[k] = 0;
    end
    e_valid = 0; e_ctx = 0; e_blk = 0;
    e_exec[0] = 0; e_exec[1] = 0;
  endtask

  task automatic check_out(input string tag);
    chk({tag, ":a_valid"}, a_out_valid, e_valid);
    chk({tag, ":b_valid"}, b_out_valid, e_valid);
    chk({tag, ":a_ctx"}, a_out_ctx, e_ctx);
    chk({tag, ":a_exec"}, a_out_exec, e_exec[0]);
    chk({tag, ":b_exec"}, b_out_exec, e_exec[1]);
    chk({tag, ":a_blk"}, a_out_in_blk, e_blk);
    chk({tag, ":b_blk"}, b_out_in_blk, e_blk);
    chk({tag, ":a_status"}, a_status, (m_stat[1] << 4) | m_stat[0]);
    chk({tag, ":b_status"}, b_status, (m_stat[1] << 4) | m_stat[0]);
  endtask

  // One cycle: drive at posedge+1, check ready, clock, check outputs.
  task automatic step(input string tag, input int v, input int ctx,
                      input int cnd, input int bs, input int len,
                      input int fwe, input int fctx, input int fval,
                      input int ordy);
    bit rdy;
    int f;
    in_valid = v[0]; in_ctx = ctx[0]; in_cond = cnd[3:0];
    in_blk_start = bs[0]; in_blk_len = len[2:0];
    flag_we = fwe[0]; flag_ctx = fctx[0]; flag_val = fval[3:0];
    out_ready = ordy[0];
    #1;
    rdy = !e_valid || ordy != 0;
    chk({tag, ":a_rdy"}, a_in_ready, rdy);
    chk({tag, ":b_rdy"}, b_in_ready, rdy);
    if (v != 0 && rdy) begin
      for (int d = 0; d < 2; d++) begin
        f = (d == 0 && fwe != 0 && fctx == ctx) ? fval : m_stat[ctx];
        if (bs != 0) e_exec[d] = 1;
        else if (m_cnt[ctx] > 0) e_exec[d] = truth(m_cond[ctx], f, d == 1);
        else e_exec[d] = truth(cnd, f, d == 1);
      end
      e_blk = (bs == 0 && m_cnt[ctx] > 0) ? 1 : 0;
      e_ctx = ctx;
      e_valid = 1;
      if (bs != 0) begin
        m_cond[ctx] = cnd;
        m_cnt[ctx] = (len > 4) ? 4 : len;
      end else if (m_cnt[ctx] > 0) begin
        m_cnt[ctx]--;
      end
    end else if (ordy != 0) begin
      e_valid = 0;
    end
    if (fwe != 0) m_stat[fctx] = fval;
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic instr(input string tag, input int ctx, input int cnd);
    step(tag, 1, ctx, cnd, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic fwrite(input int ctx, input int val);
    step("fw", 0, 0, 0, 0, 0, 1, ctx, val, 1);
  endtask

  int tab [16] = '{1,0,0,1,0,1,0,1,0,1,1,0,0,1,1,1};

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_ctx = 0; in_cond = 0; in_blk_start = 0;
    in_blk_len = 0; flag_we = 0; flag_ctx = 0; flag_val = 0;
    out_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_out("reset");
    chk("reset:a_rdy", a_in_ready, 1);

    // condition sweep with Z=1
    fwrite(0, 4'b1000);
    for (int cc = 0; cc < 16; cc++) begin
      instr("sweep", 0, cc);
      chk("sweep_tab_a", a_out_exec, tab[cc]);
      if (cc == 15) chk("sweep_nv_b", b_out_exec, 0);
    end

    // bypass vs registered flags
    fwrite(0, 0);
    step("byp", 1, 0, 0, 0, 0, 1, 0, 4'b1000, 1);
    chk("byp_a", a_out_exec, 1);
    chk("byp_b", b_out_exec, 0);
    instr("byp_next", 0, 0);
    chk("byp_next_b", b_out_exec, 1);

    // block NE len 3 with Z=1
    step("blk_start", 1, 0, 1, 1, 3, 0, 0, 0, 1);
    chk("blk_start_blk", a_out_in_blk, 0);
    for (int i = 0; i < 3; i++) begin
      instr("blk_mem", 0, 14);
      chk("blk_mem_exec", a_out_exec, 0);
      chk("blk_mem_blk", a_out_in_blk, 1);
    end
    instr("blk_after", 0, 14);
    chk("blk_after_exec", a_out_exec, 1);
    chk("blk_after_blk", a_out_in_blk, 0);

    // clamp len 7 to 4 members
    step("clamp", 1, 0, 0, 1, 7, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      instr("clamp_mem", 0, 1);
      chk("clamp_mem_blk", a_out_in_blk, 1);
    end
    instr("clamp_end", 0, 1);
    chk("clamp_end_blk", a_out_in_blk, 0);

    // restart after 2 members
    step("rs0", 1, 0, 1, 1, 4, 0, 0, 0, 1);
    instr("rs_m", 0, 14);
    instr("rs_m", 0, 14);
    step("rs1", 1, 0, 0, 1, 2, 0, 0, 0, 1);
    instr("rs_n", 0, 1);
    instr("rs_n", 0, 1);
    chk("rs_n_blk", a_out_in_blk, 1);
    instr("rs_end", 0, 1);
    chk("rs_end_blk", a_out_in_blk, 0);

    // contexts interleaved
    step("ctx_start", 1, 0, 1, 1, 2, 0, 0, 0, 1);
    instr("ctx1", 1, 14);
    chk("ctx1_blk", a_out_in_blk, 0);
    instr("ctx0", 0, 14);
    instr("ctx1", 1, 0);
    instr("ctx0", 0, 14);
    chk("ctx0_last_blk", a_out_in_blk, 1);
    instr("ctx0_end", 0, 14);

    // backpressure: 3 stalled cycles, flag write during stall
    step("bp_start", 1, 0, 1, 1, 3, 0, 0, 0, 1);
    instr("bp_m", 0, 14);
    step("bp_s", 1, 0, 14, 0, 0, 0, 0, 0, 0);
    step("bp_s", 1, 0, 14, 0, 0, 1, 0, 4'b0000, 0);
    step("bp_s", 1, 0, 14, 0, 0, 0, 0, 0, 0);
    chk("bp_hold_exec", a_out_exec, 0);
    instr("bp_go", 0, 14);
    instr("bp_go", 0, 14);
    instr("bp_go", 0, 14);

    // reset mid-block
    fwrite(0, 4'b1000);
    step("rst_start", 1, 0, 1, 1, 4, 0, 0, 0, 1);
    instr("rst_m", 0, 14);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_b_valid", b_out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", a_in_ready, 1);
    instr("rst_after", 0, 14);
    chk("rst_after_blk", a_out_in_blk, 0);
    chk("rst_after_exec", a_out_exec, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(0, 9) < 8) ? 1 : 0,
           $urandom_range(0, 1),
           $urandom_range(0, 15),
           ($urandom_range(0, 6) == 0) ? 1 : 0,
           $urandom_range(0, 7),
           ($urandom_range(0, 2) == 0) ? 1 : 0,
           $urandom_range(0, 1),
           $urandom_range(0, 15),
           ($urandom_range(0, 9) < 7) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
